// File: rtl/bp_trace_encoder_sync.sv
// Successor trace encoder: turns the committed-PC stream into SYNC / COMPRESSED /
// DIRECT_BRANCH / OVERFLOW packets queued in an in-order packet FIFO.
module bp_trace_encoder_sync #(
    parameter int         PC_WIDTH    = 32,
    parameter int         COMP_BITS   = 8,
    parameter int         FIFO_DEPTH  = 4,
    parameter int         SYNC_PERIOD = 16,
    parameter bit         RVC_EN      = 1'b1,
    parameter logic [1:0] SRC_ID      = 2'd0,
    parameter int         DROP_W      = 8
) (
    input  logic                clk_i,
    input  logic                reset_n_i,
    input  logic                trace_en_i,
    input  logic                commit_v_i,
    input  logic [PC_WIDTH-1:0] commit_pc_i,
    output logic [1:0]          trace_src_o,
    output logic [3:0]          trace_mcode_o,
    output logic [PC_WIDTH-1:0] trace_addr_o,
    output logic                trace_v_o,
    input  logic                trace_ready_i,
    output logic [15:0]         drop_total_o
);

    // Nexus message codes shared with the packet sink
    localparam logic [3:0] MCODE_DIRECT_BRANCH = 4'd3;
    localparam logic [3:0] MCODE_OVERFLOW      = 4'd8;
    localparam logic [3:0] MCODE_SYNC          = 4'd9;
    localparam logic [3:0] MCODE_COMPRESSED    = 4'd11;

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PER_W = (SYNC_PERIOD > 0) ? $clog2(SYNC_PERIOD + 1) : 1;
    localparam logic [CNT_W-1:0] DEPTH_C    = CNT_W'(FIFO_DEPTH);
    localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [PER_W-1:0] PERIOD_C   = PER_W'(SYNC_PERIOD);

    typedef enum logic [1:0] {
        ST_SYNC_PEND = 2'd0,
        ST_RUN       = 2'd1,
        ST_OVF       = 2'd2
    } state_e;

    state_e              state_reg, state_next, state_eff;
    logic [PC_WIDTH-1:0] last_pc_reg;
    logic [DROP_W-1:0]   drop_cnt_reg, drop_cnt_next, drop_cnt_inc;
    logic [15:0]         drop_total_reg, drop_total_next, drop_total_inc;
    logic [PER_W-1:0]    period_cnt_reg, period_cnt_next;
    logic                en_reg;

    logic [PTR_W-1:0]    wr_ptr_reg, wr_ptr_next, rd_ptr_reg, rd_ptr_next;
    logic [CNT_W-1:0]    count_reg, count_next;
    logic [3:0]          mem_mcode [FIFO_DEPTH];
    logic [PC_WIDTH-1:0] mem_addr  [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] wr_en;

    logic                accept, sequential, disc, compressible, has_space, rising, deq;
    logic [PC_WIDTH-1:0] delta;
    logic [PC_WIDTH-COMP_BITS:0] delta_hi;
    logic                enq;
    logic [3:0]          enq_mcode;
    logic [PC_WIDTH-1:0] enq_addr;

    assign accept       = commit_v_i && trace_en_i;
    assign delta        = commit_pc_i - last_pc_reg;
    assign sequential   = (delta == '0) || (delta == PC_WIDTH'(4)) ||
                          (RVC_EN && (delta == PC_WIDTH'(2)));
    assign disc         = accept && !sequential;
    assign delta_hi     = delta[PC_WIDTH-1:COMP_BITS-1];
    assign compressible = (&delta_hi) || !(|delta_hi);
    assign has_space    = count_reg < DEPTH_C;
    assign rising       = trace_en_i && !en_reg;

    assign drop_cnt_inc   = (&drop_cnt_reg) ? drop_cnt_reg : drop_cnt_reg + DROP_W'(1);
    assign drop_total_inc = (&drop_total_reg) ? drop_total_reg : drop_total_reg + 16'd1;

    // A re-enable restarts with a SYNC, but an overflow report is never abandoned
    assign state_eff = (rising && state_reg == ST_RUN) ? ST_SYNC_PEND : state_reg;

    always_comb begin
        state_next      = state_eff;
        drop_cnt_next   = drop_cnt_reg;
        drop_total_next = drop_total_reg;
        period_cnt_next = period_cnt_reg;
        enq             = 1'b0;
        enq_mcode       = '0;
        enq_addr        = '0;
        case (state_eff)
            ST_SYNC_PEND: begin
                if (accept && has_space) begin
                    enq             = 1'b1;
                    enq_mcode       = MCODE_SYNC;
                    enq_addr        = commit_pc_i;
                    period_cnt_next = '0;
                    state_next      = ST_RUN;
                end
            end
            ST_RUN: begin
                if (disc) begin
                    if (!has_space) begin
                        drop_cnt_next   = DROP_W'(1);
                        drop_total_next = drop_total_inc;
                        state_next      = ST_OVF;
                    end else if (SYNC_PERIOD != 0 && period_cnt_reg == PERIOD_C) begin
                        enq             = 1'b1;
                        enq_mcode       = MCODE_SYNC;
                        enq_addr        = commit_pc_i;
                        period_cnt_next = '0;
                    end else begin
                        enq             = 1'b1;
                        enq_mcode       = compressible ? MCODE_COMPRESSED : MCODE_DIRECT_BRANCH;
                        enq_addr        = compressible ? delta : commit_pc_i;
                        period_cnt_next = period_cnt_reg + PER_W'(1);
                    end
                end
            end
            ST_OVF: begin
                if (has_space) begin
                    enq           = 1'b1;
                    enq_mcode     = MCODE_OVERFLOW;
                    enq_addr      = PC_WIDTH'(drop_cnt_reg);
                    drop_cnt_next = '0;
                    state_next    = ST_SYNC_PEND;
                end else if (disc) begin
                    drop_cnt_next   = drop_cnt_inc;
                    drop_total_next = drop_total_inc;
                end
            end
            default: state_next = ST_SYNC_PEND;
        endcase
    end

    assign trace_v_o = (count_reg != '0);
    assign deq       = trace_v_o && trace_ready_i;

    always_comb begin
        wr_ptr_next = wr_ptr_reg;
        rd_ptr_next = rd_ptr_reg;
        count_next  = count_reg;
        if (enq) begin
            wr_ptr_next = (wr_ptr_reg == LAST_PTR_C) ? '0 : wr_ptr_reg + PTR_W'(1);
        end
        if (deq) begin
            rd_ptr_next = (rd_ptr_reg == LAST_PTR_C) ? '0 : rd_ptr_reg + PTR_W'(1);
        end
        case ({enq, deq})
            2'b10:   count_next = count_reg + CNT_W'(1);
            2'b01:   count_next = count_reg - CNT_W'(1);
            default: count_next = count_reg;
        endcase
    end

    genvar gi;
    generate
        for (gi = 0; gi < FIFO_DEPTH; gi++) begin : g_wr_en
            assign wr_en[gi] = enq && (wr_ptr_reg == PTR_W'(gi));
        end
    endgenerate

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (wr_en[i]) begin
                mem_mcode[i] <= enq_mcode;
                mem_addr[i]  <= enq_addr;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_n_i) begin
            state_reg      <= ST_SYNC_PEND;
            last_pc_reg    <= '0;
            drop_cnt_reg   <= '0;
            drop_total_reg <= '0;
            period_cnt_reg <= '0;
            en_reg         <= 1'b0;
            wr_ptr_reg     <= '0;
            rd_ptr_reg     <= '0;
            count_reg      <= '0;
        end else begin
            state_reg      <= state_next;
            drop_cnt_reg   <= drop_cnt_next;
            drop_total_reg <= drop_total_next;
            period_cnt_reg <= period_cnt_next;
            en_reg         <= trace_en_i;
            wr_ptr_reg     <= wr_ptr_next;
            rd_ptr_reg     <= rd_ptr_next;
            count_reg      <= count_next;
            if (accept) begin
                last_pc_reg <= commit_pc_i;
            end
        end
    end

    // Head is gated so an empty FIFO presents all-zero payload
    assign trace_mcode_o = trace_v_o ? mem_mcode[rd_ptr_reg] : '0;
    assign trace_addr_o  = trace_v_o ? mem_addr[rd_ptr_reg] : '0;
    assign trace_src_o   = SRC_ID;
    assign drop_total_o  = drop_total_reg;

endmodule

// File: tb/tb_bp_trace_encoder_sync.sv
// Scoreboard bench for bp_trace_encoder_sync: two instances (default config and
// SYNC_PERIOD=2 / RVC_EN=0) driven with directed commit sequences.
module tb_bp_trace_encoder_sync;

    localparam logic [3:0] MC_DIRECT = 4'd3;
    localparam logic [3:0] MC_OVF    = 4'd8;
    localparam logic [3:0] MC_SYNC   = 4'd9;
    localparam logic [3:0] MC_COMP   = 4'd11;

    typedef struct packed {
        logic [3:0]  mcode;
        logic [31:0] addr;
    } pkt_t;

    logic        clk = 1'b0;
    logic        reset_n, trace_en;
    logic        commit_v_a, commit_v_b, ready_a, ready_b;
    logic [31:0] commit_pc_a, commit_pc_b;
    logic [1:0]  src_a, src_b;
    logic [3:0]  mcode_a, mcode_b;
    logic [31:0] addr_a, addr_b;
    logic        v_a, v_b;
    logic [15:0] drop_a, drop_b;

    pkt_t exp_a[$];
    pkt_t exp_b[$];
    pkt_t ea, eb;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    bp_trace_encoder_sync #(
        .PC_WIDTH(32), .COMP_BITS(8), .FIFO_DEPTH(4), .SYNC_PERIOD(16),
        .RVC_EN(1'b1), .SRC_ID(2'd1), .DROP_W(8)
    ) dut_a (
        .clk_i(clk), .reset_n_i(reset_n), .trace_en_i(trace_en),
        .commit_v_i(commit_v_a), .commit_pc_i(commit_pc_a),
        .trace_src_o(src_a), .trace_mcode_o(mcode_a), .trace_addr_o(addr_a),
        .trace_v_o(v_a), .trace_ready_i(ready_a), .drop_total_o(drop_a)
    );

    bp_trace_encoder_sync #(
        .PC_WIDTH(32), .COMP_BITS(8), .FIFO_DEPTH(4), .SYNC_PERIOD(2),
        .RVC_EN(1'b0), .SRC_ID(2'd2), .DROP_W(8)
    ) dut_b (
        .clk_i(clk), .reset_n_i(reset_n), .trace_en_i(trace_en),
        .commit_v_i(commit_v_b), .commit_pc_i(commit_pc_b),
        .trace_src_o(src_b), .trace_mcode_o(mcode_b), .trace_addr_o(addr_b),
        .trace_v_o(v_b), .trace_ready_i(ready_b), .drop_total_o(drop_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic commit_a(input logic [31:0] pc);
        commit_v_a  = 1'b1;
        commit_pc_a = pc;
        tick();
        commit_v_a  = 1'b0;
    endtask

    task automatic commit_b(input logic [31:0] pc);
        commit_v_b  = 1'b1;
        commit_pc_b = pc;
        tick();
        commit_v_b  = 1'b0;
    endtask

    task automatic push_a(input logic [3:0] mc, input logic [31:0] ad);
        exp_a.push_back('{mcode: mc, addr: ad});
    endtask

    task automatic push_b(input logic [3:0] mc, input logic [31:0] ad);
        exp_b.push_back('{mcode: mc, addr: ad});
    endtask

    // Monitors: pop one expectation per accepted transfer
    always @(negedge clk) begin
        if (reset_n && v_a && ready_a) begin
            $display("A: mcode=%0d addr=0x%08h src=%0d", mcode_a, addr_a, src_a);
            if (exp_a.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL a_unexpected: got mcode %0d addr 0x%0h, required no packet", mcode_a, addr_a);
            end else begin
                ea = exp_a.pop_front();
                check("a_mcode", 32'(mcode_a), 32'(ea.mcode));
                check("a_addr", addr_a, ea.addr);
                check("a_src", 32'(src_a), 32'd1);
            end
        end
    end

    always @(negedge clk) begin
        if (reset_n && v_b && ready_b) begin
            $display("B: mcode=%0d addr=0x%08h src=%0d", mcode_b, addr_b, src_b);
            if (exp_b.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL b_unexpected: got mcode %0d addr 0x%0h, required no packet", mcode_b, addr_b);
            end else begin
                eb = exp_b.pop_front();
                check("b_mcode", 32'(mcode_b), 32'(eb.mcode));
                check("b_addr", addr_b, eb.addr);
                check("b_src", 32'(src_b), 32'd2);
            end
        end
    end

    initial begin
        reset_n     = 1'b0;
        trace_en    = 1'b1;
        commit_v_a  = 1'b0;
        commit_v_b  = 1'b0;
        commit_pc_a = '0;
        commit_pc_b = '0;
        ready_a     = 1'b1;
        ready_b     = 1'b1;
        tick();
        tick();

        check("rst_v", 32'(v_a), 32'd0);
        check("rst_mcode", 32'(mcode_a), 32'd0);
        check("rst_addr", addr_a, 32'd0);
        check("rst_drop", 32'(drop_a), 32'd0);
        check("rst_src", 32'(src_a), 32'd1);
        reset_n = 1'b1;
        tick();

        // First commit produces SYNC one cycle later; sequential ones are silent
        push_a(MC_SYNC, 32'h1000);
        commit_a(32'h1000);
        check("sync_latency", 32'(v_a), 32'd1);
        commit_a(32'h1004);
        commit_a(32'h1008);

        // Signed compressed deltas and a full-address branch
        push_a(MC_COMP, 32'hFFFF_FFF8);
        commit_a(32'h1000);
        push_a(MC_COMP, 32'h0000_0040);
        commit_a(32'h1040);
        push_a(MC_COMP, 32'hFFFF_FFB0);
        commit_a(32'h0FF0);
        push_a(MC_DIRECT, 32'h2000);
        commit_a(32'h2000);
        commit_a(32'h2002);
        commit_a(32'h2006);
        repeat (6) tick();

        // Overflow: four fit, two dropped
        ready_a = 1'b0;
        push_a(MC_DIRECT, 32'h3000);
        commit_a(32'h3000);
        push_a(MC_DIRECT, 32'h3100);
        commit_a(32'h3100);
        push_a(MC_COMP, 32'h10);
        commit_a(32'h3110);
        push_a(MC_DIRECT, 32'h3200);
        commit_a(32'h3200);
        commit_a(32'h4000);
        commit_a(32'h5000);
        tick();
        check("ovf_drop_total", 32'(drop_a), 32'd2);
        check("ovf_head_mcode", 32'(mcode_a), 32'(MC_DIRECT));
        check("ovf_head_addr", addr_a, 32'h3000);
        push_a(MC_OVF, 32'd2);
        ready_a = 1'b1;
        repeat (8) tick();
        push_a(MC_SYNC, 32'h6000);
        commit_a(32'h6000);
        repeat (3) tick();
        check("drop_total_hold", 32'(drop_a), 32'd2);

        // Disabled commits ignored; re-enable forces SYNC
        trace_en = 1'b0;
        commit_a(32'h7000);
        tick();
        trace_en = 1'b1;
        tick();
        push_a(MC_SYNC, 32'h7100);
        commit_a(32'h7100);
        repeat (4) tick();

        // Reset with queued packets discards them
        ready_a = 1'b0;
        commit_a(32'h8000);
        commit_a(32'h9000);
        commit_a(32'hA000);
        check("pre_rst_v", 32'(v_a), 32'd1);
        reset_n = 1'b0;
        tick();
        check("mid_rst_v", 32'(v_a), 32'd0);
        check("mid_rst_drop", 32'(drop_a), 32'd0);
        reset_n = 1'b1;
        ready_a = 1'b1;
        tick();
        push_a(MC_SYNC, 32'hB000);
        commit_a(32'hB000);
        repeat (4) tick();

        // Instance B: periodic SYNC every 2 branches, delta 2 not sequential
        push_b(MC_SYNC, 32'h100);
        commit_b(32'h100);
        push_b(MC_COMP, 32'h2);
        commit_b(32'h102);
        push_b(MC_DIRECT, 32'h200);
        commit_b(32'h200);
        push_b(MC_SYNC, 32'h210);
        commit_b(32'h210);
        push_b(MC_COMP, 32'h10);
        commit_b(32'h220);
        push_b(MC_COMP, 32'h10);
        commit_b(32'h230);
        commit_b(32'h234);
        repeat (10) tick();

        check("a_queue_empty", 32'(exp_a.size()), 32'd0);
        check("b_queue_empty", 32'(exp_b.size()), 32'd0);
        check("b_drop_total", 32'(drop_b), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
